// File: rtl/multi_freq_sweep.sv
// Frequency sweep sequencer: steps a measurement unit through a frequency
// table, averages 2^n results per point and stores amplitude/phase per step.
module multi_freq_sweep #(
    parameter int N_MAX     = 33,
    parameter int AW        = 6,
    parameter int FREQ_W    = 14,
    parameter int AMP_W     = 12,
    parameter int PH_W      = 12,
    parameter int DLY_W     = 16,
    parameter int DLY_SPLIT = 11,
    parameter int DLY_LONG  = 10000,
    parameter int DLY_SHORT = 5000,
    parameter int TMO_W     = 32,
    parameter int TMO_CYC   = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cont_mode,
    input  logic [AW-1:0]     num_pts,
    input  logic [1:0]        avg_log2,
    input  logic              tbl_we,
    input  logic [AW-1:0]     tbl_waddr,
    input  logic [FREQ_W-1:0] tbl_wdata,
    input  logic [AW-1:0]     raddr,
    output logic [AMP_W-1:0]  amp_rd,
    output logic [PH_W-1:0]   phase_rd,
    output logic              unit_start,
    output logic [FREQ_W-1:0] unit_freq,
    output logic [DLY_W-1:0]  unit_delay_us,
    input  logic              unit_done,
    input  logic [AMP_W-1:0]  unit_amp,
    input  logic [PH_W-1:0]   unit_phase,
    output logic              busy,
    output logic              done,
    output logic              err_tmo,
    output logic [AW-1:0]     cur_step
);

    localparam int SAW = AMP_W + 3;
    localparam int SPW = PH_W + 3;
    localparam int CW  = 4;
    localparam logic [AW-1:0]    NMAX_A   = AW'(N_MAX);
    localparam logic [AW-1:0]    SPLIT_A  = AW'(DLY_SPLIT);
    localparam logic [DLY_W-1:0] DL_A     = DLY_W'(DLY_LONG);
    localparam logic [DLY_W-1:0] DS_A     = DLY_W'(DLY_SHORT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_UNIT, ACCUM, STORE, NEXT, FIN
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            step_q, step_d;
    logic [AW-1:0]            npts_q, npts_d;
    logic [1:0]               avg_q, avg_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [SAW-1:0]           sum_amp_q, sum_amp_d;
    logic signed [SPW-1:0]    sum_ph_q, sum_ph_d;
    logic [AMP_W-1:0]         smp_amp_q, smp_amp_d;
    logic [PH_W-1:0]          smp_ph_q, smp_ph_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     err_q, err_d;
    logic [FREQ_W-1:0]        ufreq_q, ufreq_d;
    logic [DLY_W-1:0]         udly_q, udly_d;

    logic [FREQ_W-1:0]        tbl_q [N_MAX];
    logic [AMP_W-1:0]         res_amp_q [N_MAX];
    logic [PH_W-1:0]          res_ph_q [N_MAX];

    logic                     res_we;
    logic [AMP_W-1:0]         res_amp_w;
    logic [PH_W-1:0]          res_ph_w;
    logic [FREQ_W-1:0]        launch_freq;
    logic [DLY_W-1:0]         launch_dly;
    logic [CW-1:0]            cnt_nx;

    function automatic logic [FREQ_W-1:0] dflt_freq(input int i);
        int v;
        if (i < 5)        v = 5 + i;
        else if (i < 14)  v = (i - 4) * 10;
        else if (i < 23)  v = (i - 13) * 100;
        else if (i < 32)  v = (i - 22) * 1000;
        else if (i == 32) v = 10000;
        else              v = 0;
        return FREQ_W'(v);
    endfunction

    assign launch_freq = tbl_q[step_q];
    assign launch_dly  = (step_q < SPLIT_A) ? DL_A : DS_A;
    assign cnt_nx      = cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        npts_d    = npts_q;
        avg_d     = avg_q;
        cnt_d     = cnt_q;
        sum_amp_d = sum_amp_q;
        sum_ph_d  = sum_ph_q;
        smp_amp_d = smp_amp_q;
        smp_ph_d  = smp_ph_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        ufreq_d   = ufreq_q;
        udly_d    = udly_q;
        res_we    = 1'b0;
        res_amp_w = '0;
        res_ph_w  = '0;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        npts_d    = (num_pts == '0 || num_pts > NMAX_A)
                                    ? NMAX_A : num_pts;
                        avg_d     = avg_log2;
                        step_d    = '0;
                        cnt_d     = '0;
                        sum_amp_d = '0;
                        sum_ph_d  = '0;
                        err_d     = 1'b0;
                        state_d   = LAUNCH;
                    end
                end
                LAUNCH: begin
                    ufreq_d = launch_freq;
                    udly_d  = launch_dly;
                    tmo_d   = '0;
                    state_d = WAIT_UNIT;
                end
                WAIT_UNIT: begin
                    // unit data is only valid alongside the done pulse
                    if (unit_done) begin
                        smp_amp_d = unit_amp;
                        smp_ph_d  = unit_phase;
                        state_d   = ACCUM;
                    end else if (tmo_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        res_we  = 1'b1;
                        state_d = NEXT;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ACCUM: begin
                    sum_amp_d = sum_amp_q + {3'b000, smp_amp_q};
                    sum_ph_d  = sum_ph_q
                              + {{3{smp_ph_q[PH_W-1]}}, smp_ph_q};
                    cnt_d     = cnt_nx;
                    state_d   = (cnt_nx == (CW'(1) << avg_q))
                                ? STORE : LAUNCH;
                end
                STORE: begin
                    res_we    = 1'b1;
                    res_amp_w = AMP_W'(sum_amp_q >> avg_q);
                    res_ph_w  = PH_W'(sum_ph_q >>> avg_q);
                    state_d   = NEXT;
                end
                NEXT: begin
                    sum_amp_d = '0;
                    sum_ph_d  = '0;
                    cnt_d     = '0;
                    if (step_q == npts_q - AW'(1)) begin
                        state_d = FIN;
                    end else begin
                        step_d  = step_q + AW'(1);
                        state_d = LAUNCH;
                    end
                end
                FIN: begin
                    if (cont_mode) begin
                        step_d  = '0;
                        state_d = LAUNCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            npts_q    <= '0;
            avg_q     <= '0;
            cnt_q     <= '0;
            sum_amp_q <= '0;
            sum_ph_q  <= '0;
            smp_amp_q <= '0;
            smp_ph_q  <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            ufreq_q   <= '0;
            udly_q    <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            npts_q    <= npts_d;
            avg_q     <= avg_d;
            cnt_q     <= cnt_d;
            sum_amp_q <= sum_amp_d;
            sum_ph_q  <= sum_ph_d;
            smp_amp_q <= smp_amp_d;
            smp_ph_q  <= smp_ph_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            ufreq_q   <= ufreq_d;
            udly_q    <= udly_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_MAX; i++) tbl_q[i] <= dflt_freq(i);
        end else if (tbl_we && state_q == IDLE && tbl_waddr < NMAX_A) begin
            tbl_q[tbl_waddr] <= tbl_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_MAX; i++) begin
                res_amp_q[i] <= '0;
                res_ph_q[i]  <= '0;
            end
        end else if (res_we) begin
            res_amp_q[step_q] <= res_amp_w;
            res_ph_q[step_q]  <= res_ph_w;
        end
    end

    // LAUNCH presents the new point combinationally so it lines up with unit_start
    assign unit_freq     = (state_q == LAUNCH) ? launch_freq : ufreq_q;
    assign unit_delay_us = (state_q == LAUNCH) ? launch_dly : udly_q;
    assign unit_start    = (state_q == LAUNCH) && !abort;
    assign done          = (state_q == FIN) && !abort;
    assign busy          = (state_q != IDLE);
    assign cur_step      = busy ? step_q : '0;
    assign err_tmo       = err_q;
    assign amp_rd        = (raddr < NMAX_A) ? res_amp_q[raddr] : '0;
    assign phase_rd      = (raddr < NMAX_A) ? res_ph_q[raddr] : '0;

endmodule

// File: tb/tb_multi_freq_sweep.sv
// Directed bench for multi_freq_sweep with a behavioural measurement unit
// that answers each unit_start after a fixed latency.
module tb_multi_freq_sweep;

    localparam int AW = 6;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          cont_mode;
    logic [AW-1:0] num_pts;
    logic [1:0]    avg_log2;
    logic          tbl_we;
    logic [AW-1:0] tbl_waddr;
    logic [13:0]   tbl_wdata;
    logic [AW-1:0] raddr;
    logic [11:0]   amp_rd;
    logic [11:0]   phase_rd;
    logic          unit_start;
    logic [13:0]   unit_freq;
    logic [15:0]   unit_delay_us;
    logic          unit_done;
    logic [11:0]   unit_amp;
    logic [11:0]   unit_phase;
    logic          busy;
    logic          done;
    logic          err_tmo;
    logic [AW-1:0] cur_step;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_starts = 0;
    int n_done = 0;
    int last_done_cyc = 0;
    int freq_log [512];
    int dly_log  [512];
    int step_log [512];
    int scyc_log [512];
    int resp_mode = 0;
    int amp_base = 0;
    int k_base = 0;
    int drop_step = -1;
    int rk, ridx, rs;

    int exp_freq [33] = '{5, 6, 7, 8, 9, 10, 20, 30, 40, 50, 60, 70, 80, 90,
                          100, 200, 300, 400, 500, 600, 700, 800, 900,
                          1000, 2000, 3000, 4000, 5000, 6000, 7000, 8000,
                          9000, 10000};

    multi_freq_sweep #(.TMO_CYC(50)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cont_mode(cont_mode), .num_pts(num_pts), .avg_log2(avg_log2),
        .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
        .raddr(raddr), .amp_rd(amp_rd), .phase_rd(phase_rd),
        .unit_start(unit_start), .unit_freq(unit_freq),
        .unit_delay_us(unit_delay_us), .unit_done(unit_done),
        .unit_amp(unit_amp), .unit_phase(unit_phase), .busy(busy),
        .done(done), .err_tmo(err_tmo), .cur_step(cur_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) begin
            n_done++;
            last_done_cyc = cyc;
        end
    end

    // measurement unit model
    initial begin
        unit_done = 1'b0;
        unit_amp = '0;
        unit_phase = '0;
        forever begin
            @(negedge clk);
            if (unit_start === 1'b1) begin
                rk = int'(cur_step);
                ridx = n_starts % 512;
                freq_log[ridx] = int'(unit_freq);
                dly_log[ridx] = int'(unit_delay_us);
                step_log[ridx] = rk;
                scyc_log[ridx] = cyc;
                rs = n_starts - k_base;
                n_starts++;
                if (rk != drop_step) begin
                    repeat (9) @(negedge clk);
                    unit_done = 1'b1;
                    if (resp_mode == 1) begin
                        unit_amp = 12'(10 + rs);
                        unit_phase = (rs == 3) ? 12'hffb : 12'hffc;
                    end else begin
                        unit_amp = 12'(amp_base + rk);
                        unit_phase = 12'(-rk);
                    end
                    @(negedge clk);
                    unit_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input int np, input int avg);
        @(negedge clk);
        num_pts = AW'(np);
        avg_log2 = 2'(avg);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_starts(input int tgt, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_starts >= tgt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_dones(input int tgt, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done >= tgt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cont_mode = 1'b0;
        num_pts = '0;
        avg_log2 = '0;
        tbl_we = 1'b0;
        tbl_waddr = '0;
        tbl_wdata = '0;
        raddr = 6'd3;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, unit_start, err_tmo} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {busy, done, unit_start, err_tmo});
        end
        checks++;
        if (unit_freq !== 14'd0 || unit_delay_us !== 16'd0) begin
            errors++;
            $display("FAIL reset_unit: got freq %0d dly %0d expected 0 0",
                     unit_freq, unit_delay_us);
        end
        checks++;
        if (cur_step !== 6'd0) begin
            errors++;
            $display("FAIL reset_step: got %0d expected 0", cur_step);
        end
        checks++;
        if (amp_rd !== 12'd0 || phase_rd !== 12'd0) begin
            errors++;
            $display("FAIL reset_result: got %0d/%0d expected 0/0",
                     amp_rd, phase_rd);
        end
    endtask

    task automatic test_default_sweep;
        int s0, d0;
        bit ok;
        logic [11:0] ep;
        s0 = n_starts;
        d0 = n_done;
        amp_base = 0;
        do_start(0, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL dflt_busy: got %b expected 1", busy);
        end
        wait_idle(3000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dflt_idle: got busy expected idle");
        end
        checks++;
        if (n_starts - s0 !== 33) begin
            errors++;
            $display("FAIL dflt_starts: got %0d expected 33", n_starts - s0);
        end
        checks++;
        if (n_done - d0 !== 1) begin
            errors++;
            $display("FAIL dflt_done: got %0d expected 1", n_done - d0);
        end
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (freq_log[(s0 + i) % 512] !== exp_freq[i]
                || step_log[(s0 + i) % 512] !== i) begin
                errors++;
                $display("FAIL dflt_freq[%0d]: got %0d step %0d expected %0d",
                         i, freq_log[(s0 + i) % 512],
                         step_log[(s0 + i) % 512], exp_freq[i]);
            end
            checks++;
            if (dly_log[(s0 + i) % 512] !== ((i < 11) ? 10000 : 5000)) begin
                errors++;
                $display("FAIL dflt_dly[%0d]: got %0d expected %0d", i,
                         dly_log[(s0 + i) % 512], (i < 11) ? 10000 : 5000);
            end
            raddr = AW'(i);
            ep = 12'(-i);
            #1;
            checks++;
            if (amp_rd !== 12'(i) || phase_rd !== ep) begin
                errors++;
                $display("FAIL dflt_res[%0d]: got %0d/%h expected %0d/%h",
                         i, amp_rd, phase_rd, i, ep);
            end
        end
        raddr = 6'd33;
        #1;
        checks++;
        if (amp_rd !== 12'd0 || phase_rd !== 12'd0) begin
            errors++;
            $display("FAIL rd_oob33: got %0d/%0d expected 0/0",
                     amp_rd, phase_rd);
        end
        raddr = 6'd63;
        #1;
        checks++;
        if (amp_rd !== 12'd0 || phase_rd !== 12'd0) begin
            errors++;
            $display("FAIL rd_oob63: got %0d/%0d expected 0/0",
                     amp_rd, phase_rd);
        end
    endtask

    task automatic test_averaging;
        int s0, d0;
        bit ok;
        s0 = n_starts;
        d0 = n_done;
        k_base = n_starts;
        resp_mode = 1;
        do_start(1, 2);
        wait_idle(500, ok);
        resp_mode = 0;
        checks++;
        if (!ok || n_starts - s0 !== 4 || n_done - d0 !== 1) begin
            errors++;
            $display("FAIL avg_counts: got starts %0d done %0d expected 4 1",
                     n_starts - s0, n_done - d0);
        end
        checks++;
        if (step_log[(s0 + 3) % 512] !== 0 || freq_log[(s0 + 3) % 512] !== 5) begin
            errors++;
            $display("FAIL avg_point: got step %0d freq %0d expected 0 5",
                     step_log[(s0 + 3) % 512], freq_log[(s0 + 3) % 512]);
        end
        raddr = 6'd0;
        #1;
        checks++;
        if (amp_rd !== 12'd11 || phase_rd !== 12'hffb) begin
            errors++;
            $display("FAIL avg_result: got %0d/%h expected 11/ffb",
                     amp_rd, phase_rd);
        end
    endtask

    task automatic test_timeout;
        int s0, d0;
        bit ok;
        s0 = n_starts;
        d0 = n_done;
        drop_step = 2;
        do_start(4, 0);
        wait_idle(600, ok);
        drop_step = -1;
        checks++;
        if (!ok || n_starts - s0 !== 4 || n_done - d0 !== 1) begin
            errors++;
            $display("FAIL tmo_counts: got starts %0d done %0d expected 4 1",
                     n_starts - s0, n_done - d0);
        end
        checks++;
        if (err_tmo !== 1'b1) begin
            errors++;
            $display("FAIL tmo_flag: got %b expected 1", err_tmo);
        end
        raddr = 6'd2;
        #1;
        checks++;
        if (amp_rd !== 12'd0 || phase_rd !== 12'd0) begin
            errors++;
            $display("FAIL tmo_res2: got %0d/%h expected 0/000",
                     amp_rd, phase_rd);
        end
        raddr = 6'd1;
        #1;
        checks++;
        if (amp_rd !== 12'd1 || phase_rd !== 12'hfff) begin
            errors++;
            $display("FAIL tmo_res1: got %0d/%h expected 1/fff",
                     amp_rd, phase_rd);
        end
        raddr = 6'd3;
        #1;
        checks++;
        if (amp_rd !== 12'd3 || phase_rd !== 12'hffd) begin
            errors++;
            $display("FAIL tmo_res3: got %0d/%h expected 3/ffd",
                     amp_rd, phase_rd);
        end
    endtask

    task automatic test_abort_writes;
        int s0, d0;
        bit ok;
        amp_base = 100;
        @(negedge clk);
        tbl_we = 1'b1;
        tbl_waddr = 6'd0;
        tbl_wdata = 14'd123;
        @(negedge clk);
        tbl_we = 1'b0;
        s0 = n_starts;
        d0 = n_done;
        do_start(0, 0);
        checks++;
        if (err_tmo !== 1'b0) begin
            errors++;
            $display("FAIL abort_errclr: got %b expected 0", err_tmo);
        end
        tbl_we = 1'b1;
        tbl_waddr = 6'd1;
        tbl_wdata = 14'd999;
        @(negedge clk);
        tbl_we = 1'b0;
        wait_starts(s0 + 6, 400, ok);
        checks++;
        if (!ok || cur_step !== 6'd5) begin
            errors++;
            $display("FAIL abort_reach: got step %0d expected 5", cur_step);
        end
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy %b expected 0", busy);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (n_done !== d0 || n_starts - s0 !== 6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got done %0d starts %0d expected 0 6",
                     n_done - d0, n_starts - s0);
        end
        checks++;
        if (freq_log[s0 % 512] !== 123 || freq_log[(s0 + 1) % 512] !== 6) begin
            errors++;
            $display("FAIL tbl_write: got %0d/%0d expected 123/6",
                     freq_log[s0 % 512], freq_log[(s0 + 1) % 512]);
        end
        raddr = 6'd4;
        #1;
        checks++;
        if (amp_rd !== 12'd104) begin
            errors++;
            $display("FAIL abort_res4: got %0d expected 104", amp_rd);
        end
        raddr = 6'd5;
        #1;
        checks++;
        if (amp_rd !== 12'd5 || phase_rd !== 12'hffb) begin
            errors++;
            $display("FAIL abort_res5: got %0d/%h expected 5/ffb",
                     amp_rd, phase_rd);
        end
        amp_base = 0;
    endtask

    task automatic test_cont_mode;
        int s0, d0;
        bit ok;
        s0 = n_starts;
        d0 = n_done;
        cont_mode = 1'b1;
        do_start(2, 0);
        wait_dones(d0 + 1, 300, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || n_starts - s0 !== 3
            || scyc_log[(s0 + 2) % 512] !== last_done_cyc + 1
            || step_log[(s0 + 2) % 512] !== 0) begin
            errors++;
            $display("FAIL cont_gap1: got starts %0d at %0d expected 3 at %0d",
                     n_starts - s0, scyc_log[(s0 + 2) % 512], last_done_cyc + 1);
        end
        wait_dones(d0 + 2, 300, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || n_starts - s0 !== 5
            || scyc_log[(s0 + 4) % 512] !== last_done_cyc + 1) begin
            errors++;
            $display("FAIL cont_gap2: got starts %0d at %0d expected 5 at %0d",
                     n_starts - s0, scyc_log[(s0 + 4) % 512], last_done_cyc + 1);
        end
        cont_mode = 1'b0;
        wait_idle(300, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || n_done - d0 !== 3 || n_starts - s0 !== 6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop: got done %0d starts %0d expected 3 6",
                     n_done - d0, n_starts - s0);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int d0, s1;
        bit ok;
        d0 = n_done;
        do_start(0, 0);
        repeat (40) @(negedge clk);
        rst = 1'b0;
        raddr = 6'd0;
        #1;
        checks++;
        if (busy !== 1'b0 || unit_freq !== 14'd0 || cur_step !== 6'd0
            || amp_rd !== 12'd0) begin
            errors++;
            $display("FAIL rst_mid: got busy %b freq %0d step %0d amp %0d expected 0",
                     busy, unit_freq, cur_step, amp_rd);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (n_done !== d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_nodone: got done %0d busy %b expected 0 0",
                     n_done - d0, busy);
        end
        s1 = n_starts;
        do_start(1, 0);
        wait_idle(200, ok);
        checks++;
        if (!ok || freq_log[s1 % 512] !== 5) begin
            errors++;
            $display("FAIL rst_table: got %0d expected 5", freq_log[s1 % 512]);
        end
    endtask

    initial begin
        test_reset();
        test_default_sweep();
        test_averaging();
        test_timeout();
        test_abort_writes();
        test_cont_mode();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_freq_sweep.md
MULTI_FREQ_SWEEP -- requirements
Module: multi_freq_sweep

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  N_MAX 33, frequency-table and result-memory depth;
  AW 6, table/result address width;
  FREQ_W 14, frequency word width, units of 100 Hz;
  AMP_W 12, amplitude width, unsigned Q12.0;
  PH_W 12, phase width, signed Q3.9;
  DLY_W 16, settle-delay width, us;
  DLY_SPLIT 11, first index using DLY_SHORT;
  DLY_LONG 10000, settle delay for indices below DLY_SPLIT;
  DLY_SHORT 5000, settle delay for other indices;
  TMO_W 32, timeout counter width;
  TMO_CYC 100000000, cycles allowed per unit measurement.
REQ-002 SHALL have ports (name direction width meaning), one per line:
  clk in 1 clock;
  rst in 1 reset, asynchronous, active-low;
  start in 1 sweep request, sampled in IDLE only;
  abort in 1 stop sweep, honoured in any non-IDLE state;
  cont_mode in 1 restart automatically after each completed sweep;
  num_pts in AW points per sweep, latched at start;
  avg_log2 in 2 measurements averaged per point = 2^avg_log2, latched at start;
  tbl_we in 1 frequency-table write strobe;
  tbl_waddr in AW table write address;
  tbl_wdata in FREQ_W table write data;
  raddr in AW result read address;
  amp_rd out AMP_W amplitude at raddr;
  phase_rd out PH_W phase at raddr;
  unit_start out 1 one-cycle start pulse to the measurement unit;
  unit_freq out FREQ_W frequency under test;
  unit_delay_us out DLY_W settle delay for the unit;
  unit_done in 1 unit-complete pulse;
  unit_amp in AMP_W unit amplitude, valid with unit_done;
  unit_phase in PH_W unit phase, valid with unit_done;
  busy out 1 sweep in progress;
  done out 1 one-cycle pulse at sweep completion;
  err_tmo out 1 sticky timeout flag;
  cur_step out AW index currently being measured.

Function
REQ-003 SHALL use FSM states IDLE, LAUNCH, WAIT_UNIT, ACCUM, STORE, NEXT, FIN.
REQ-004 SHALL, in IDLE with start=1, latch num_pts (0 treated as N_MAX; values above N_MAX clamped to N_MAX) and avg_log2, clear step, clear accumulators and go to LAUNCH; busy=1 from the next cycle.
REQ-005 SHALL, in LAUNCH, drive unit_freq=table[step] and unit_delay_us=DLY_LONG if step<DLY_SPLIT else DLY_SHORT, pulse unit_start for exactly one cycle, clear the timeout counter and go to WAIT_UNIT.
REQ-006 SHALL hold unit_freq and unit_delay_us stable from LAUNCH until the next LAUNCH or IDLE.
REQ-007 SHALL, in WAIT_UNIT, go to ACCUM on unit_done; unit_done in any other state SHALL be ignored.
REQ-008 SHALL, in ACCUM, add unit_amp (zero-extended) to an AMP_W+3-bit sum and unit_phase (sign-extended) to a PH_W+3-bit sum, then return to LAUNCH until 2^avg_log2 samples are taken, else go to STORE.
REQ-009 SHALL, in STORE, write sum_amp>>avg_log2 (logical shift) and sum_phase>>>avg_log2 (arithmetic shift, truncated to width) to result[step]; phase wrap at +/-pi is not corrected.
REQ-010 SHALL, in NEXT, clear the sums, then go to FIN if step==num_pts-1, else increment step and go to LAUNCH.
REQ-011 SHALL, in FIN, pulse done for one cycle, then go to LAUNCH with step=0 if cont_mode=1 and abort=0, else go to IDLE.
REQ-012 SHALL, on abort, go to IDLE on the next cycle without a done pulse, with no unit_start issued and no result write in that cycle; results already stored are kept.
REQ-013 SHALL, when the timeout counter in WAIT_UNIT reaches TMO_CYC, set err_tmo, store amp=0 and phase=0 for that step, and continue at NEXT.
REQ-014 SHALL clear err_tmo only on reset or on an accepted start.
REQ-015 SHALL accept table writes only when busy=0; writes with busy=1 or tbl_waddr>=N_MAX SHALL be dropped.
REQ-016 SHALL drive amp_rd and phase_rd combinationally from raddr; raddr>=N_MAX SHALL read 0.
REQ-017 SHALL drive cur_step=step and busy=1 in every state except IDLE.

Reset
REQ-018 SHALL, on rst=0, asynchronously enter IDLE with busy, done, unit_start, err_tmo, unit_freq, unit_delay_us, cur_step, step and sums all 0, and all result entries 0.
REQ-019 SHALL load the frequency table on reset with the default table (100 Hz units): 5,6,7,8,9; 10,20..90; 100,200..900; 1000,2000..9000; 10000; unused entries 0.
REQ-020 SHALL, on reset asserted mid-sweep, discard the sweep with no done pulse.

Verification
REQ-021 Default sweep: start, num_pts=0, avg_log2=0, unit_done 10 cycles after each unit_start with amp=index -> 33 unit_start pulses, unit_freq 5..10000, delay 10000 for indices 0-10 and 5000 after, single done, amp_rd[k]=k.
REQ-022 Averaging: avg_log2=2, num_pts=1, samples amp 10,11,12,13, phase -4,-4,-4,-5 -> 4 unit_start pulses, result amp=11, phase=-5.
REQ-023 Timeout: TMO_CYC=50, no unit_done at step 2 of num_pts=4 -> err_tmo=1, result[2]=0, steps 0,1,3 valid, done pulses once.
REQ-024 Abort and writes: abort during WAIT_UNIT at step 5 -> IDLE next cycle, no done; tbl_we while busy is dropped; tbl_we in IDLE to address 0 with 123 -> next sweep unit_freq=123 at step 0.
REQ-025 Continuous mode: cont_mode=1, num_pts=2 -> done every sweep and unit_start for step 0 without an idle gap; clearing cont_mode -> IDLE after the current done.
